// File: rtl/add_share_arb.sv
// Purpose    : round-robin arbiter sharing one W-bit adder between NREQ requesters.
// Latency    : operands accepted in cycle N appear as a registered result in cycle N+1.
// Backpressure: a held result (rsp_valid && !rsp_ready) blocks all grants; req_ready stays 0.
//
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   req_valid/req_ready        - per-requester handshake (req_ready is one-hot or zero)
//   req_a, req_b               - packed operands, requester i owns slice [i*W +: W]
//   rsp_valid/rsp_ready        - result handshake towards the consumer
//   rsp_id, rsp_sum, rsp_carry - winner index, (a+b) mod 2^W, carry out of bit W-1
//   op_cnt                     - wrapping count of completed result handshakes
module add_share_arb #(
  parameter int W    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_carry,
  output logic [15:0]       op_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_sum_q, rsp_sum_d;
  logic           rsp_carry_q, rsp_carry_d;
  logic [15:0]    op_cnt_q, op_cnt_d;

  logic           load_en;
  logic           any_vld;
  logic           grant;
  logic           rsp_hs;
  logic [IDW-1:0] winner;
  logic [IDW:0]   scan_idx;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [W:0]     sum_full;

  // The result register can take a new value when it is empty or being drained.
  assign load_en = (state_q == EMPTY) || rsp_ready;
  assign rsp_hs  = (state_q == FULL) && rsp_ready;

  // Rotating priority scan starting at ptr_q. The index is kept one bit wider
  // than IDW so ptr+k never overflows before the wrap at NREQ, which matters
  // when NREQ is not a power of two.
  always_comb begin
    any_vld  = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(NREQ)) begin
        scan_idx = scan_idx - (IDW+1)'(NREQ);
      end
      if (!any_vld && req_valid[scan_idx[IDW-1:0]]) begin
        any_vld = 1'b1;
        winner  = scan_idx[IDW-1:0];
      end
    end
  end

  // rst_n gates the grant so no requester sees an accept while reset is held,
  // even though the empty result register would otherwise allow a load.
  assign grant = load_en && any_vld && rst_n;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Operand mux: constant slice per requester, selected by the winner index.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        op_a = req_a[i*W +: W];
        op_b = req_b[i*W +: W];
      end
    end
  end

  // Both operands are zero-extended so the carry lands in bit W.
  assign sum_full = {1'b0, op_a} + {1'b0, op_b};

  // Output-register FSM and datapath next state.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    op_cnt_d    = op_cnt_q;

    case (state_q)
      EMPTY: begin
        if (grant) begin
          state_d = FULL;
        end
      end
      FULL: begin
        // With a grant in the same cycle the register reloads with no bubble.
        if (rsp_ready && !grant) begin
          state_d = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (grant) begin
      rsp_id_d    = winner;
      rsp_sum_d   = sum_full[W-1:0];
      rsp_carry_d = sum_full[W];
      if (winner == IDW'(NREQ-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = winner + IDW'(1);
      end
    end

    if (rsp_hs) begin
      op_cnt_d = op_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      ptr_q       <= '0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      op_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      op_cnt_q    <= op_cnt_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign op_cnt    = op_cnt_q;

endmodule

// File: doc/add_share_arb.md
# add_share_arb

Round-robin arbiter that shares one W-bit adder between NREQ requesters. Each requester offers an operand pair over a valid/ready handshake. The arbiter grants one requester per cycle, computes the sum and carry, and holds the result in a single output register until the consumer accepts it. It sits between the operand producers and the adder consumer, so the adder needs no per-client copy.

## Interface
- `W`, default 4: operand and sum width.
- `NREQ`, default 4: number of requesters, 2..16.
- `IDW`, default `$clog2(NREQ)`: requester-id width. Derived; do not override.

Ports (name, direction, width, meaning):
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, NREQ: bit i means requester i offers operands.
- `req_a`, in, NREQ*W: operand A; slice [i*W +: W] belongs to requester i.
- `req_b`, in, NREQ*W: operand B, same slicing as `req_a`.
- `req_ready`, out, NREQ: one-hot or zero; bit i high means requester i is accepted this cycle.
- `rsp_valid`, out, 1: the result register holds an unaccepted result.
- `rsp_ready`, in, 1: the consumer accepts the result.
- `rsp_id`, out, IDW: index of the requester that produced the result.
- `rsp_sum`, out, W: (a+b) mod 2^W.
- `rsp_carry`, out, 1: bit W of a+b.
- `op_cnt`, out, 16: count of completed response handshakes; wraps.

## Operation
- Internal state:
  - `ptr` (IDW bits): round-robin start pointer.
  - Output register: `rsp_valid`, `rsp_id`, `rsp_sum`, `rsp_carry`.
  - `op_cnt`.
- Per-output FSM with two states:
  - EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
  - EMPTY->FULL on grant.
  - FULL->EMPTY on `rsp_ready` with no grant.
  - FULL->FULL on `rsp_ready` with grant (back-to-back), or on no `rsp_ready` (hold).
- `load_en` = !`rsp_valid` || `rsp_ready`. This is combinational.
- Grant selection:
  - Winner = first i with `req_valid`[i], searching `ptr`, `ptr`+1, … mod NREQ.
  - A grant occurs iff `load_en` and at least one `req_valid` bit is set.
  - `req_ready`[winner]=1 in the same cycle. All other `req_ready` bits are 0.
  - `req_ready` is 0 whenever `load_en` is 0, regardless of `req_valid`.
- On grant, at the next edge:
  - `rsp_sum`/`rsp_carry` <= W+1-bit sum of the winner's operands, zero-extended.
  - `rsp_id` <= winner.
  - `rsp_valid` <= 1.
  - `ptr` <= (winner+1) mod NREQ. For non-power-of-two NREQ, wrap at NREQ, not 2^IDW.
- No grant: `ptr` is unchanged.
- While FULL with `rsp_ready`=0, all `rsp_*` outputs hold stable.
- `op_cnt` increments by 1 on each edge where `rsp_valid`&&`rsp_ready`; it wraps 0xFFFF->0x0000.
- Requesters must hold `req_a`/`req_b` stable while `req_valid` is high and not yet accepted. The arbiter samples operands only in the granted cycle.
- A requester may drop `req_valid` before it is granted. It is then simply skipped; there is no error.
- Width rule: the sum is computed at W+1 bits. Truncating the carry is a defect. Widths must match exactly, with no implicit nets or width mismatches.

## Timing
- Reset (`rst_n`=0, asynchronous assert) sets:
  - `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_carry`=0, `op_cnt`=0, `ptr`=0.
  - `req_ready` = 0 while reset is asserted.
- Deassertion is synchronous to `clk` (externally synchronized). The first grant is possible in the first cycle after release.
- Reset mid-operation: any pending result is discarded without a handshake, and `op_cnt` clears.
- Latency: request accepted in cycle N -> `rsp_valid`=1 with its result in cycle N+1.
- Throughput: 1 result per cycle while `rsp_ready` is held at 1.
- Backpressure: with `rsp_ready`=0 and FULL, zero requests are accepted.
- Simultaneous `rsp_valid`&&`rsp_ready` and a new grant:
  - The old result completes (`op_cnt`++).
  - The new result loads at the same edge, with no bubble.
- Fairness: with all requesters continuously valid and `rsp_ready`=1, grants go 0,1,2,…,NREQ-1,0,… Each requester waits at most NREQ-1 grants.

## Test plan
- Reset then single request, NREQ=4, W=4:
  - `req_valid`=0b0001, a=0x3, b=0x4, `rsp_ready`=1.
  - Expect `req_ready`=0b0001 that cycle, next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_sum`=0x7, `rsp_carry`=0, then `op_cnt`=1.
- Carry/wrap:
  - Requester 2 sends a=0xF, b=0x1 -> `rsp_sum`=0x0, `rsp_carry`=1, `rsp_id`=2.
  - Requester 1 sends a=0x9, b=0x8 -> `rsp_sum`=0x1, `rsp_carry`=1.
- Round-robin:
  - All 4 requesters valid for 8 cycles, `rsp_ready`=1.
  - Expect `rsp_id` sequence 0,1,2,3,0,1,2,3 and one `req_ready` bit per cycle.
  - Then only requester 0 stays valid after a grant to 3 -> next grant is 0.
- Backpressure:
  - Result pending and `rsp_ready`=0 for 5 cycles with all requests valid.
  - Expect `req_ready`=0 and `rsp_*` held stable.
  - Raise `rsp_ready` -> the next winner is `ptr`'s requester and loads at the same edge (no bubble).
- Reset mid-operation:
  - Assert `rst_n`=0 asynchronously while FULL.
  - Expect `rsp_valid`=0 and `op_cnt`=0 immediately, before any clock edge.
  - After release, requester 3 alone valid -> granted in the first post-reset cycle.
- Counter wrap:
  - Force 65536 handshakes (or preload via long run).
  - Expect `op_cnt` sequence 0xFFFF -> 0x0000.
